// File: rtl/pb_debounce.sv
// pb_debounce: synchronizes and debounces the active-low push-button pin and
// classifies each accepted press as short or long using one-cycle pulses.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   PB_raw    in   asynchronous button pin, active-low (0 = pressed)
//   PB_clean  out  debounced level, same polarity as PB_raw
//   pressed   out  pulse: debounced press accepted
//   long_hold out  pulse: press has lasted LONG_CYC cycles
//   short_rel out  pulse: release of a press that never became long
//   long_rel  out  pulse: release of a long press
// All outputs are registered.

module pb_debounce #(
  parameter int unsigned DEB_CYC  = 16,
  parameter int unsigned LONG_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic PB_raw,
  output logic PB_clean,
  output logic pressed,
  output logic long_hold,
  output logic short_rel,
  output logic long_rel
);

  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam int unsigned HW = $clog2(LONG_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_e;

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  state_e        state_q, state_d;
  logic          pressed_q, pressed_d;
  logic          long_hold_q, long_hold_d;
  logic          short_rel_q, short_rel_d;
  logic          long_rel_q, long_rel_d;

  logic differ_c;
  logic accept_c;
  logic accept_fall_c;
  logic accept_rise_c;

  // Two-flop synchronizer; idles high so reset looks like a released button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= PB_raw;
      sync2_q <= sync1_q;
    end
  end

  // Stability counter: a change is accepted on the DEB_CYC-th consecutive disagreeing cycle
  always_comb begin
    differ_c      = (sync2_q != clean_q);
    accept_c      = differ_c && (deb_cnt_q == DW'(DEB_CYC - 1));
    accept_fall_c = accept_c && !sync2_q;
    accept_rise_c = accept_c && sync2_q;
    clean_d       = accept_c ? sync2_q : clean_q;
    deb_cnt_d     = (differ_c && !accept_c) ? deb_cnt_q + DW'(1) : '0;
  end

  // Press FSM next-state and event pulses; a release beats the long threshold
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    pressed_d   = 1'b0;
    long_hold_d = 1'b0;
    short_rel_d = 1'b0;
    long_rel_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_fall_c) begin
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
          state_d    = HELD;
        end
      end
      HELD: begin
        if (accept_rise_c) begin
          short_rel_d = 1'b1;
          state_d     = IDLE;
        end else begin
          // Registered pulse lands in the cycle the count shows LONG_CYC-1
          if (hold_cnt_q == HW'(LONG_CYC - 2)) begin
            long_hold_d = 1'b1;
            state_d     = LONG;
          end
          if (hold_cnt_q != HW'(LONG_CYC)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      LONG: begin
        if (accept_rise_c) begin
          long_rel_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clean_q     <= 1'b1;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      state_q     <= IDLE;
      pressed_q   <= 1'b0;
      long_hold_q <= 1'b0;
      short_rel_q <= 1'b0;
      long_rel_q  <= 1'b0;
    end else begin
      clean_q     <= clean_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      state_q     <= state_d;
      pressed_q   <= pressed_d;
      long_hold_q <= long_hold_d;
      short_rel_q <= short_rel_d;
      long_rel_q  <= long_rel_d;
    end
  end

  assign PB_clean  = clean_q;
  assign pressed   = pressed_q;
  assign long_hold = long_hold_q;
  assign short_rel = short_rel_q;
  assign long_rel  = long_rel_q;

endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce: directed scenarios plus randomized button activity, checked
// every cycle against a behavioural model of the debouncer and press classifier.

module tb_pb_debounce;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;

  logic clk = 1'b0;
  logic rst;
  logic PB_raw;
  logic PB_clean, pressed, long_hold, short_rel, long_rel;

  always #5 clk = ~clk;

  pb_debounce #(.DEB_CYC(DEB), .LONG_CYC(LNG)) dut (
    .clk      (clk),
    .rst      (rst),
    .PB_raw   (PB_raw),
    .PB_clean (PB_clean),
    .pressed  (pressed),
    .long_hold(long_hold),
    .short_rel(short_rel),
    .long_rel (long_rel)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: delayed pin view, run length of disagreement, press age
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_clean = 1'b1;
  int m_run = 0, m_age = 0, m_phase = 0;  // phase: 0 idle, 1 pressed, 2 long
  bit m_pr = 1'b0, m_lh = 1'b0, m_sr = 1'b0, m_lr = 1'b0;

  // Tallies of DUT events for directed checks
  int n_pr, n_lh, n_sr, n_lr, n_fall;
  int p_cyc, lh_cyc, sr_cyc, lr_cyc;
  bit prev_clean = 1'b1;

  task automatic model_edge(input bit r, input bit raw);
    bit s, fall, rise;
    m_pr = 1'b0; m_lh = 1'b0; m_sr = 1'b0; m_lr = 1'b0;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_clean = 1'b1;
      m_run = 0; m_phase = 0; m_age = 0;
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = raw;
    fall = 1'b0; rise = 1'b0;
    if (s != m_clean) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_clean = s;
        m_run   = 0;
        fall    = !s;
        rise    = s;
      end
    end else begin
      m_run = 0;
    end
    if (fall) begin
      m_pr = 1'b1; m_phase = 1; m_age = 0;
    end else if (rise) begin
      if (m_phase == 1) m_sr = 1'b1;
      else if (m_phase == 2) m_lr = 1'b1;
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_age++;
      if (m_age == int'(LNG) - 1) begin
        m_lh = 1'b1; m_phase = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    n_pr = 0; n_lh = 0; n_sr = 0; n_lr = 0; n_fall = 0;
    p_cyc = -1; lh_cyc = -1; sr_cyc = -1; lr_cyc = -1;
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge
  task automatic step(input bit r, input bit raw);
    rst = r; PB_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    cyc++;
    @(negedge clk);
    chk("PB_clean", PB_clean, m_clean);
    chk("pressed", pressed, m_pr);
    chk("long_hold", long_hold, m_lh);
    chk("short_rel", short_rel, m_sr);
    chk("long_rel", long_rel, m_lr);
    n_tests++;
    assert ($countones({pressed, long_hold, short_rel, long_rel}) <= 1) else begin
      n_fail++;
      $error("FAIL exclusive: got %b%b%b%b expected at most one high (cycle %0d)",
             pressed, long_hold, short_rel, long_rel, cyc);
    end
    if (pressed === 1'b1)   begin n_pr++; p_cyc = cyc; end
    if (long_hold === 1'b1) begin n_lh++; lh_cyc = cyc; end
    if (short_rel === 1'b1) begin n_sr++; sr_cyc = cyc; end
    if (long_rel === 1'b1)  begin n_lr++; lr_cyc = cyc; end
    if (prev_clean && (PB_clean === 1'b0)) n_fall++;
    prev_clean = (PB_clean !== 1'b0);
  endtask

  task automatic run(input int n, input bit raw);
    for (int i = 0; i < n; i++) step(1'b0, raw);
  endtask

  initial begin
    int c0;
    bit lvl;
    int len;
    bit bounce[7];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    PB_raw = 1'b1;
    clr();

    // Reset held with the pin low, then press latency and a short press
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("reset_clean", PB_clean, 1'b1);
    chk("reset_pressed", pressed, 1'b0);
    clr();
    c0 = cyc;
    run(12, 1'b0);
    chk_int("press_count_a", n_pr, 1);
    chk_int("press_latency", p_cyc - c0, 6);
    run(4, 1'b0);
    run(15, 1'b1);
    chk_int("short_rel_count", n_sr, 1);
    chk_int("short_no_long", n_lh + n_lr, 0);

    // Bounce before a sustained low, continuing into a long press
    run(10, 1'b1);
    clr();
    c0 = cyc;
    for (int i = 0; i < 7; i++) step(1'b0, bounce[i]);
    run(12, 1'b0);
    chk_int("bounce_press_count", n_pr, 1);
    chk_int("bounce_fall_count", n_fall, 1);
    chk_int("bounce_press_cycle", p_cyc - c0, 12);
    run(33, 1'b0);
    chk_int("long_hold_count", n_lh, 1);
    chk_int("long_hold_cycle", lh_cyc - p_cyc, 19);
    run(12, 1'b1);
    chk_int("long_rel_count", n_lr, 1);
    chk_int("long_no_short", n_sr, 0);

    // Release landing exactly on the long threshold
    run(10, 1'b1);
    clr();
    run(6, 1'b0);
    run(13, 1'b0);
    run(10, 1'b1);
    chk_int("collide_short_cycle", sr_cyc - p_cyc, 19);
    chk_int("collide_no_long", n_lh + n_lr, 0);

    // One cycle later the press becomes long first
    run(10, 1'b1);
    clr();
    run(20, 1'b0);
    run(10, 1'b1);
    chk_int("late_long_cycle", lh_cyc - p_cyc, 19);
    chk_int("late_long_rel_cycle", lr_cyc - p_cyc, 20);
    chk_int("late_no_short", n_sr, 0);

    // Three-cycle glitch on an idle pin
    run(10, 1'b1);
    clr();
    run(3, 1'b0);
    run(12, 1'b1);
    chk_int("glitch_events", n_pr + n_lh + n_sr + n_lr + n_fall, 0);

    // Reset while in the long state, pin still held
    clr();
    run(26, 1'b0);
    chk_int("pre_reset_long", n_lh, 1);
    step(1'b1, 1'b0);
    chk("mid_reset_clean", PB_clean, 1'b1);
    c0 = cyc;
    run(12, 1'b0);
    chk_int("reset_no_long_rel", n_lr, 0);
    chk_int("repress_count", n_pr, 2);
    chk_int("repress_latency", p_cyc - c0, 6);
    run(12, 1'b1);
    chk_int("repress_short_rel", n_sr, 1);
    chk_int("repress_no_long_rel", n_lr, 0);

    // Randomized activity with bounce and occasional reset
    for (int seg = 0; seg < 200; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 45));
      for (int i = 0; i < len; i++) begin
        if (($urandom % 150) == 0) step(1'b1, lvl);
        else if (i < 4 && ($urandom % 3) == 0) step(1'b0, !lvl);
        else step(1'b0, lvl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
